// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction fetch + IF/ID register, optional delay-slot squash via DELAY_SLOT_SQUASH_EN
module pipe_if_stage #(
    parameter int          ADDR_W = 8,
    parameter logic [31:0] RST_PC = 32'h00000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        pcsource,
    input  logic [7:0]        bpc,
    input  logic [7:0]        jpc,
    input  logic [31:0]       jrpc,
    input  logic              wpcir,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       pc,
    output logic [31:0]       dpc4,
    output logic [31:0]       inst,
    output logic              ivalid
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_dpc4, r_inst, r_hold, r_pend_pc;
    logic        r_ivalid, r_pend_v;
    logic [31:0] w_pc4, w_target, w_npc, w_word;
    logic        w_redir, w_take, w_fill, w_bubble, w_sq;
    assign w_pc4    = r_pc + 32'd4;
    assign w_redir  = r_ivalid & wpcir & (pcsource != 2'b00);
    assign w_target = pcsource == 2'b01 ? {24'h0, bpc} : pcsource == 2'b10 ? jrpc : {24'h0, jpc};
    assign w_npc    = w_redir ? w_target : (r_pend_v ? r_pend_pc : w_pc4);
    assign w_take   = wpcir & ((r_state == HOLD) | imem_ready);
    assign w_fill   = (r_state == RUN) & imem_ready & ~wpcir;
    assign w_bubble = (r_state == RUN) & ~imem_ready & wpcir;
    assign w_word   = r_state == HOLD ? r_hold : imem_rdata;
`ifdef DELAY_SLOT_SQUASH_EN
    logic r_squash;
    assign w_sq = r_squash | w_redir;
    // remember an unconsumed redirect until the next accepted word, which is annulled
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) r_squash <= 1'b0;
        else        r_squash <= w_take ? 1'b0 : w_sq;
    end
`else
    assign w_sq = 1'b0;
`endif
    // FSM state register
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) r_state <= RUN;
        else        r_state <= w_next;
    end
    // FSM next state: park a completed fetch while decode stalls
    always_comb begin
        w_next = r_state == RUN ? (w_fill ? HOLD : RUN) : (wpcir ? RUN : HOLD);
    end
    // FSM outputs: request only in RUN and never while reset is held
    always_comb begin
        imem_req = (r_state == RUN) & ~resetn;
    end
    // fetch PC, pending redirect, hold buffer and IF/ID register
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_pc      <= RST_PC;
            r_dpc4    <= 32'h0;
            r_inst    <= 32'h0;
            r_ivalid  <= 1'b0;
            r_hold    <= 32'h0;
            r_pend_pc <= 32'h0;
            r_pend_v  <= 1'b0;
        end else begin
            if (w_take) begin
                r_dpc4   <= w_pc4;
                r_inst   <= w_sq ? 32'h0 : w_word;
                r_ivalid <= ~w_sq;
                r_pc     <= w_npc;
                r_pend_v <= 1'b0;
            end else if (w_bubble) begin
                r_inst   <= 32'h0;
                r_ivalid <= 1'b0;
                if (w_redir) begin
                    r_pend_pc <= w_target;
                    r_pend_v  <= 1'b1;
                end
            end
            if (w_fill) r_hold <= imem_rdata;
        end
    end
    assign imem_addr = r_pc[ADDR_W-1:0];
    assign pc        = r_pc;
    assign dpc4      = r_dpc4;
    assign inst      = r_inst;
    assign ivalid    = r_ivalid;
endmodule

// File: tb/tb_pipe_if_stage.sv
// tb_pipe_if_stage: directed checks of fetch, redirects, wait states, hold and PC wrap
module tb_pipe_if_stage;
    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [7:0]  bpc = 8'h0;
    logic [7:0]  jpc = 8'h0;
    logic [31:0] jrpc = 32'h0;
    logic        wpcir = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic [31:0] pc, dpc4, inst;
    logic        ivalid;
    int          checks = 0;
    int          errors = 0;
`ifdef DELAY_SLOT_SQUASH_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif
    pipe_if_stage #(.ADDR_W(8), .RST_PC(32'h0)) dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
        .jrpc(jrpc), .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .dpc4(dpc4),
        .inst(inst), .ivalid(ivalid)
    );
    assign imem_rdata = {24'hC0DE00, imem_addr};
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_dpc4,
                        input logic [31:0] e_inst, input logic e_v);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".dpc4"}, dpc4, e_dpc4);
        check({tag, ".inst"}, inst, e_inst);
        check({tag, ".ivalid"}, {31'h0, ivalid}, {31'h0, e_v});
    endtask
    initial begin
        tick;
        tick;
        ifid("rst0", 32'h0, 32'h0, 32'h0, 1'b0);
        check("rst0.req", {31'h0, imem_req}, 32'h0);
        resetn = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("rel0.req", {31'h0, imem_req}, 32'h1);
        tick;
        tick;
        ifid("run8", 32'h8, 32'h8, 32'hC0DE0004, 1'b1);
        imem_ready = 1'b0;
        tick;
        ifid("wait8", 32'h8, 32'h8, 32'h0, 1'b0);
        check("wait8.req", {31'h0, imem_req}, 32'h1);
        #2 resetn = 1'b1;
        #1;
        ifid("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("midrst.req", {31'h0, imem_req}, 32'h0);
        tick;
        resetn = 1'b0;
        imem_ready = 1'b1;
        #1;
        ifid("c1", 32'h0, 32'h0, 32'h0, 1'b0);
        check("c1.req", {31'h0, imem_req}, 32'h1);
        tick;
        ifid("c2", 32'h4, 32'h4, 32'hC0DE0000, 1'b1);
        tick;
        ifid("c3", 32'h8, 32'h8, 32'hC0DE0004, 1'b1);
        tick;
        tick;
        tick;
        ifid("beq", 32'h14, 32'h14, 32'hC0DE0010, 1'b1);
        check("beq.addr", {24'h0, imem_addr}, 32'h14);
        pcsource = 2'b01;
        bpc = 8'h40;
        tick;
        ifid("slot", 32'h40, 32'h18, SQ ? 32'h0 : 32'hC0DE0014, !SQ);
        check("slot.addr", {24'h0, imem_addr}, 32'h40);
        pcsource = 2'b00;
        tick;
        ifid("tgt", 32'h44, 32'h44, 32'hC0DE0040, 1'b1);
        pcsource = 2'b11;
        jpc = 8'h80;
        imem_ready = 1'b0;
        tick;
        ifid("bub1", 32'h44, 32'h44, 32'h0, 1'b0);
        pcsource = 2'b00;
        tick;
        ifid("bub2", 32'h44, 32'h44, 32'h0, 1'b0);
        check("bub2.addr", {24'h0, imem_addr}, 32'h44);
        check("bub2.req", {31'h0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        tick;
        ifid("jslot", 32'h80, 32'h48, SQ ? 32'h0 : 32'hC0DE0044, !SQ);
        check("jslot.addr", {24'h0, imem_addr}, 32'h80);
        wpcir = 1'b0;
        tick;
        ifid("hold1", 32'h80, 32'h48, SQ ? 32'h0 : 32'hC0DE0044, !SQ);
        check("hold1.req", {31'h0, imem_req}, 32'h0);
        tick;
        ifid("hold2", 32'h80, 32'h48, SQ ? 32'h0 : 32'hC0DE0044, !SQ);
        check("hold2.req", {31'h0, imem_req}, 32'h0);
        wpcir = 1'b1;
        tick;
        ifid("unhold", 32'h84, 32'h84, 32'hC0DE0080, 1'b1);
        check("unhold.req", {31'h0, imem_req}, 32'h1);
        check("unhold.addr", {24'h0, imem_addr}, 32'h84);
        tick;
        ifid("nodup", 32'h88, 32'h88, 32'hC0DE0084, 1'b1);
        pcsource = 2'b10;
        jrpc = 32'hFFFFFFFC;
        tick;
        ifid("jr", 32'hFFFFFFFC, 32'h8C, SQ ? 32'h0 : 32'hC0DE0088, !SQ);
        check("jr.addr", {24'h0, imem_addr}, 32'hFC);
        pcsource = 2'b00;
        tick;
        ifid("wrap", 32'h0, 32'h0, 32'hC0DE00FC, 1'b1);
        check("wrap.addr", {24'h0, imem_addr}, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
